aes_cipher_iter: RTL



---
 rtl/aes_cipher_iter.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/aes_cipher_iter.sv
// aes_cipher_iter: iterative AES encryption core that computes one round per clock.
// KEY_BITS selects AES-128, AES-192 or AES-256.
// A key-load FSM expands the key once into an internal round-key store.
// Blocks then stream through valid/ready handshakes.
// Optional build macro AES_ITER_ZEROIZE_EN adds a zeroize_i port. It wipes
// all key material and cipher state.
module aes_cipher_iter #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_vld_i,
  input  logic [KEY_BITS-1:0] key_i,
  output logic                key_rdy_o,
  input  logic                in_vld_i,
  input  logic [127:0]        in_data_i,
  output logic                in_rdy_o,
  output logic                out_vld_o,
  output logic [127:0]        out_data_o,
  input  logic                out_rdy_i,
  output logic                busy_o
`ifdef AES_ITER_ZEROIZE_EN
  ,
  input  logic                zeroize_i
`endif
);
  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);
  localparam int IW = $clog2(NW);

  // FIPS-197 S-box, byte b lives at bits [8b +: 8] counted from the left.
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} state_t;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int n = 0; n < 16; n++) r[8*n +: 8] = sbox(s[8*n +: 8]);
    return r;
  endfunction

  // Byte n sits at [127-8n -: 8]; byte n = 4*column + row.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c+w)%4)+w) -: 8];
    return r;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) r[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
    return r;
  endfunction

  state_t        state_q, state_d;
  logic [31:0]   w_q [NW];
  logic [IW-1:0] i_q, i_d;
  logic [2:0]    imod_q, imod_d;
  logic [7:0]    rcon_q, rcon_d;
  logic          key_ok_q, key_ok_d;
  logic [127:0]  st_q, st_d;
  logic [3:0]    rnd_q, rnd_d;
  logic          out_vld_q, out_vld_d;
  logic [127:0]  out_data_q, out_data_d;
  logic          key_load, kexp_we, zero_req;
  logic [31:0]   w_prev, w_back, sub_word_in, kexp_temp, kexp_word;
  logic [127:0]  sub_in, sb_out, sr_out, mc_out, rk0, rk_cur, round_out;
  logic [IW-1:0] rk_idx;

`ifdef AES_ITER_ZEROIZE_EN
  assign zero_req = zeroize_i;
`else
  assign zero_req = 1'b0;
`endif

  // The single subBytes instance is shared between the idle-time key expansion
  // (SubWord on the top 32 bits) and the cipher rounds.
  assign w_prev      = w_q[i_q - IW'(1)];
  assign w_back      = w_q[i_q - IW'(NK)];
  assign sub_word_in = (imod_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
  assign sub_in      = (state_q == KEXP) ? {sub_word_in, 96'h0} : st_q;
  assign sb_out      = sub_bytes(sub_in);
  assign sr_out      = shift_rows(sb_out);
  assign mc_out      = mix_columns(sr_out);
  assign rk_idx      = IW'({rnd_q, 2'b00});
  assign rk_cur      = {w_q[rk_idx], w_q[rk_idx + IW'(1)], w_q[rk_idx + IW'(2)], w_q[rk_idx + IW'(3)]};
  assign rk0         = {w_q[0], w_q[1], w_q[2], w_q[3]};
  assign round_out   = ((rnd_q == 4'(NR)) ? sr_out : mc_out) ^ rk_cur;

  // Key-schedule word transform, selected by the position of i within a key length.
  always_comb begin
    kexp_temp = w_prev;
    if (imod_q == 3'd0)
      kexp_temp = sb_out[127:96] ^ {rcon_q, 24'h0};
    else if (NK == 8 && imod_q == 3'd4)
      kexp_temp = sb_out[127:96];
  end
  assign kexp_word = w_back ^ kexp_temp;

  // Next-state and datapath control; zeroize overrides every handshake.
  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    imod_d     = imod_q;
    rcon_d     = rcon_q;
    key_ok_d   = key_ok_q;
    st_d       = st_q;
    rnd_d      = rnd_q;
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    key_load   = 1'b0;
    kexp_we    = 1'b0;
    case (state_q)
      IDLE: begin
        // A key offered together with a block takes precedence.
        if (key_vld_i) begin
          key_load = 1'b1;
          i_d      = IW'(NK);
          imod_d   = 3'd0;
          rcon_d   = 8'h01;
          key_ok_d = 1'b0;
          state_d  = KEXP;
        end else if (in_vld_i && key_ok_q) begin
          st_d    = in_data_i ^ rk0;
          rnd_d   = 4'd1;
          state_d = ROUND;
        end
      end
      KEXP: begin
        kexp_we = 1'b1;
        i_d     = i_q + IW'(1);
        imod_d  = (imod_q == 3'(NK - 1)) ? 3'd0 : imod_q + 3'd1;
        if (imod_q == 3'd0) rcon_d = xtime(rcon_q);
        if (i_q == IW'(NW - 1)) begin
          key_ok_d = 1'b1;
          state_d  = IDLE;
        end
      end
      ROUND: begin
        st_d = round_out;
        if (rnd_q == 4'(NR)) begin
          out_data_d = round_out;
          out_vld_d  = 1'b1;
          state_d    = DONE;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      DONE: begin
        if (out_rdy_i) begin
          out_vld_d = 1'b0;
          if (in_vld_i && key_ok_q) begin
            st_d    = in_data_i ^ rk0;
            rnd_d   = 4'd1;
            state_d = ROUND;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (zero_req) begin
      state_d    = IDLE;
      st_d       = '0;
      out_data_d = '0;
      out_vld_d  = 1'b0;
      key_ok_d   = 1'b0;
      key_load   = 1'b0;
      kexp_we    = 1'b0;
    end
  end

  // Control and cipher-state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      i_q        <= IW'(NK);
      imod_q     <= 3'd0;
      rcon_q     <= 8'h01;
      key_ok_q   <= 1'b0;
      st_q       <= '0;
      rnd_q      <= 4'd0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      imod_q     <= imod_d;
      rcon_q     <= rcon_d;
      key_ok_q   <= key_ok_d;
      st_q       <= st_d;
      rnd_q      <= rnd_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
    end
  end

  // Round-key store: the key is loaded whole, then one expanded word is written per KEXP cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NW; k++) w_q[k] <= '0;
    end else if (zero_req) begin
      for (int k = 0; k < NW; k++) w_q[k] <= '0;
    end else if (key_load) begin
      for (int k = 0; k < NK; k++) w_q[k] <= key_i[KEY_BITS-1-32*k -: 32];
    end else if (kexp_we) begin
      w_q[i_q] <= kexp_word;
    end
  end

  assign key_rdy_o  = (state_q == IDLE);
  assign in_rdy_o   = key_ok_q & ((state_q == IDLE) | ((state_q == DONE) & out_rdy_i));
  assign out_vld_o  = out_vld_q;
  assign out_data_o = out_data_q;
  assign busy_o     = (state_q == KEXP) | (state_q == ROUND);

endmodule
